// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: trap vectors,
// cause codes, trap-state encoding and the IF/ID register layout.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_IRQ  = 2'd1,
    CAUSE_EXC  = 2'd2
  } cause_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } trap_state_e;

  typedef enum logic [2:0] {
    ACT_EXC      = 3'd0,
    ACT_REDIRECT = 3'd1,
    ACT_IRQ      = 3'd2,
    ACT_STALL    = 3'd3,
    ACT_SEQ      = 3'd4
  } action_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    cause_e      cause;
  } ifid_t;

  // Non-instruction IF/ID content; a non-NONE cause marks a trap bubble carrying the EPC.
  function automatic ifid_t makeBubble(input logic [31:0] pc, input cause_e cause);
    ifid_t b;
    b.valid = 1'b0;
    b.instr = 32'h0;
    b.pc    = pc;
    b.cause = cause;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory port, decode control inputs and IF/ID outputs.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc;
  logic        irq;
  logic        irq_ack;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [1:0]  id_cause;

  modport master (
    output imem_addr, irq_ack, id_valid, id_instr, id_pc, id_cause,
    input  imem_data, stall, redirect_valid, redirect_pc, exc, irq
  );

  modport slave (
    input  imem_addr, irq_ack, id_valid, id_instr, id_pc, id_cause,
    output imem_data, stall, redirect_valid, redirect_pc, exc, irq
  );
endinterface

// File: rtl/if_stage_pc_next_sel.sv
// Priority selector for the fetch stage: exc > redirect > irq-take > stall > sequential.
module pc_next_sel
  import mips_fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  ifid_t       i_ifid,
  input  logic [31:0] i_imemData,
  input  logic        i_stall,
  input  logic        i_redirectValid,
  input  logic [31:0] i_redirectPc,
  input  logic        i_exc,
  input  logic        i_irq,
  input  trap_state_e i_state,
  output logic [31:0] o_nextPc,
  output ifid_t       o_nextIfid,
  output action_e     o_action,
  output logic        o_irqAck
);

  logic w_irqTake;

  // Interrupts are only taken from user space, outside the post-trap cycle,
  // and never while decode is stalled or something higher-priority fires.
  assign w_irqTake = i_irq && !i_pc[31] && !i_stall && !i_redirectValid &&
                     !i_exc && (i_state == ST_RUN);

  always_comb begin
    o_action      = ACT_SEQ;
    o_nextPc      = i_pc + 32'd4;
    o_nextIfid    = makeBubble(i_pc, CAUSE_NONE);
    o_nextIfid.valid = 1'b1;
    o_nextIfid.instr = i_imemData;
    o_irqAck      = 1'b0;

    if (i_exc) begin
      o_action   = ACT_EXC;
      o_nextPc   = EXC_VEC;
      o_nextIfid = makeBubble(i_ifid.pc, CAUSE_EXC);
    end else if (i_redirectValid) begin
      o_action   = ACT_REDIRECT;
      o_nextPc   = i_redirectPc;
      o_nextIfid = makeBubble(32'h0, CAUSE_NONE);
    end else if (w_irqTake) begin
      // EPC is the word being fetched; the instruction in decode still retires.
      o_action   = ACT_IRQ;
      o_nextPc   = IRQ_VEC;
      o_nextIfid = makeBubble(i_pc, CAUSE_IRQ);
      o_irqAck   = 1'b1;
    end else if (i_stall) begin
      o_action   = ACT_STALL;
      o_nextPc   = i_pc;
      o_nextIfid = i_ifid;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and the RUN/TRAP
// state that keeps two traps from landing back to back.
module if_stage
  import mips_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  bus
);

  logic [31:0] r_pc;
  ifid_t       r_ifid;
  trap_state_e r_state;

  trap_state_e w_nextState;
  logic [31:0] w_nextPc;
  ifid_t       w_nextIfid;
  action_e     w_action;
  logic        w_irqAck;

  pc_next_sel u_sel (
    .i_pc            (r_pc),
    .i_ifid          (r_ifid),
    .i_imemData      (bus.imem_data),
    .i_stall         (bus.stall),
    .i_redirectValid (bus.redirect_valid),
    .i_redirectPc    (bus.redirect_pc),
    .i_exc           (bus.exc),
    .i_irq           (bus.irq),
    .i_state         (r_state),
    .o_nextPc        (w_nextPc),
    .o_nextIfid      (w_nextIfid),
    .o_action        (w_action),
    .o_irqAck        (w_irqAck)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= RESET_VEC;
      r_ifid <= makeBubble(32'h0, CAUSE_NONE);
    end else begin
      r_pc   <= w_nextPc;
      r_ifid <= w_nextIfid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_nextState;
  end

  // TRAP lasts exactly the cycle after a trap is taken.
  always_comb begin
    w_nextState = ST_RUN;
    if (w_action == ACT_EXC || w_action == ACT_IRQ)
      w_nextState = ST_TRAP;
  end

  assign bus.imem_addr = r_pc;
  assign bus.irq_ack   = w_irqAck;
  assign bus.id_valid  = r_ifid.valid;
  assign bus.id_instr  = r_ifid.instr;
  assign bus.id_pc     = r_ifid.pc;
  assign bus.id_cause  = r_ifid.cause;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed cycles push expected results,
// a monitor process pops and compares them after each clock edge.
module tb_if_stage;

  typedef struct {
    string       tag;
    logic        ack;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] idPc;
    logic [1:0]  cause;
  } exp_t;

  logic clk;
  logic reset;
  int   testsRun;
  int   failCount;
  logic ackSample;
  exp_t expQ[$];

  if_stage_if bus();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory model: word 0 is 08000003, each further word adds 0x100.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h0800_0003 + ({24'h0, a[9:2]} << 8);
  endfunction

  assign bus.imem_data = memWord(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    if ($isunknown(exp)) return;
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic st, input logic rv,
                               input logic [31:0] rpc, input logic ex, input logic iq,
                               input logic eAck, input logic [31:0] ePc, input logic eValid,
                               input logic [31:0] eInstr, input logic [31:0] eIdPc,
                               input logic [1:0] eCause);
    exp_t e;
    @(negedge clk);
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.exc            = ex;
    bus.irq            = iq;
    e.tag   = tag;
    e.ack   = eAck;
    e.pc    = ePc;
    e.valid = eValid;
    e.instr = eInstr;
    e.idPc  = eIdPc;
    e.cause = eCause;
    expQ.push_back(e);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".pc"},    bus.imem_addr, 32'h8000_0000);
    checkOutput({tag, ".ack"},   {31'h0, bus.irq_ack}, 32'h0);
    checkOutput({tag, ".valid"}, {31'h0, bus.id_valid}, 32'h0);
    checkOutput({tag, ".instr"}, bus.id_instr, 32'h0);
    checkOutput({tag, ".idpc"},  bus.id_pc, 32'h0);
    checkOutput({tag, ".cause"}, {30'h0, bus.id_cause}, 32'h0);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 20; i++) begin
      if (expQ.size() == 0) break;
      @(posedge clk);
      #2;
    end
    checkOutput("drain", expQ.size(), 32'h0);
  endtask

  // Monitor: irq_ack is combinational, so it is sampled mid-cycle; registered
  // outputs are sampled just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2 ackSample = bus.irq_ack;
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".ack"},   {31'h0, ackSample}, {31'h0, e.ack});
        checkOutput({e.tag, ".pc"},    bus.imem_addr, e.pc);
        checkOutput({e.tag, ".valid"}, {31'h0, bus.id_valid}, {31'h0, e.valid});
        checkOutput({e.tag, ".instr"}, bus.id_instr, e.instr);
        checkOutput({e.tag, ".idpc"},  bus.id_pc, e.idPc);
        checkOutput({e.tag, ".cause"}, {30'h0, bus.id_cause}, {30'h0, e.cause});
      end
    end
  end

  initial begin
    testsRun  = 0;
    failCount = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.exc = 1'b0;
    bus.irq = 1'b0;
    #3 checkResetState("reset");
    @(posedge clk);
    #2 reset = 1'b0;

    // Sequential fetch out of the reset vector
    applyStimulus("seq0", 0, 0, 0, 0, 0, 0, 32'h8000_0004, 1, 32'h0800_0003, 32'h8000_0000, 0);
    applyStimulus("seq1", 0, 0, 0, 0, 0, 0, 32'h8000_0008, 1, 32'h0800_0103, 32'h8000_0004, 0);
    applyStimulus("seq2", 0, 0, 0, 0, 0, 0, 32'h8000_000C, 1, 32'h0800_0203, 32'h8000_0008, 0);
    applyStimulus("seq3", 0, 0, 0, 0, 0, 0, 32'h8000_0010, 1, 32'h0800_0303, 32'h8000_000C, 0);

    // Redirect, then redirect with stall
    applyStimulus("redir", 0, 1, 32'h8000_000C, 0, 0, 0, 32'h8000_000C, 0, 32'h0, 'x, 0);
    applyStimulus("redirT", 0, 0, 0, 0, 0, 0, 32'h8000_0010, 1, 32'h0800_0303, 32'h8000_000C, 0);
    applyStimulus("redirSt", 1, 1, 32'h8000_000C, 0, 0, 0, 32'h8000_000C, 0, 32'h0, 'x, 0);
    applyStimulus("redirStT", 0, 0, 0, 0, 0, 0, 32'h8000_0010, 1, 32'h0800_0303, 32'h8000_000C, 0);

    // Stall at 000000D8 (irq during a stall is not taken)
    applyStimulus("toD4", 0, 1, 32'h0000_00D4, 0, 0, 0, 32'h0000_00D4, 0, 32'h0, 'x, 0);
    applyStimulus("atD8", 0, 0, 0, 0, 0, 0, 32'h0000_00D8, 1, 32'h0800_3503, 32'h0000_00D4, 0);
    applyStimulus("stall1", 1, 0, 0, 0, 0, 0, 32'h0000_00D8, 1, 32'h0800_3503, 32'h0000_00D4, 0);
    applyStimulus("stall2", 1, 0, 0, 0, 0, 0, 32'h0000_00D8, 1, 32'h0800_3503, 32'h0000_00D4, 0);
    applyStimulus("stall3", 1, 0, 0, 0, 1, 0, 32'h0000_00D8, 1, 32'h0800_3503, 32'h0000_00D4, 0);
    applyStimulus("unstall", 0, 0, 0, 0, 0, 0, 32'h0000_00DC, 1, 32'h0800_3603, 32'h0000_00D8, 0);

    // IRQ taken in user mode, then held through TRAP and kernel mode
    applyStimulus("to100", 0, 1, 32'h0000_0100, 0, 0, 0, 32'h0000_0100, 0, 32'h0, 'x, 0);
    applyStimulus("irqTake", 0, 0, 0, 0, 1, 1, 32'h8000_0004, 0, 32'h0, 32'h0000_0100, 1);
    applyStimulus("irqTrap", 0, 0, 0, 0, 1, 0, 32'h8000_0008, 1, 32'h0800_0103, 32'h8000_0004, 0);
    applyStimulus("irqKern", 0, 0, 0, 0, 1, 0, 32'h8000_000C, 1, 32'h0800_0203, 32'h8000_0008, 0);

    // IRQ while fetching from 80000100 is never acknowledged
    applyStimulus("to80000100", 0, 1, 32'h8000_0100, 0, 1, 0, 32'h8000_0100, 0, 32'h0, 'x, 0);
    applyStimulus("irqK100", 0, 0, 0, 0, 1, 0, 32'h8000_0104, 1, 32'h0800_4003, 32'h8000_0100, 0);

    // irq + redirect in the same cycle: redirect wins, irq taken next cycle
    applyStimulus("to40", 0, 1, 32'h0000_0040, 0, 0, 0, 32'h0000_0040, 0, 32'h0, 'x, 0);
    applyStimulus("irqRedir", 0, 1, 32'h0000_0020, 0, 1, 0, 32'h0000_0020, 0, 32'h0, 'x, 0);
    applyStimulus("irqAfter", 0, 0, 0, 0, 1, 1, 32'h8000_0004, 0, 32'h0, 32'h0000_0020, 1);
    applyStimulus("isrSeq", 0, 0, 0, 0, 0, 0, 32'h8000_0008, 1, 32'h0800_0103, 32'h8000_0004, 0);

    // Exception (with a competing irq) on the instruction at 00000058
    applyStimulus("to58", 0, 1, 32'h0000_0058, 0, 0, 0, 32'h0000_0058, 0, 32'h0, 'x, 0);
    applyStimulus("at5C", 0, 0, 0, 0, 0, 0, 32'h0000_005C, 1, 32'h0800_1603, 32'h0000_0058, 0);
    applyStimulus("exc", 0, 0, 0, 1, 1, 0, 32'h8000_0008, 0, 32'h0, 32'h0000_0058, 2);
    waitDrain();

    // Asynchronous reset in the TRAP cycle
    #1 reset = 1'b1;
    #1 checkResetState("midReset");
    @(posedge clk);
    #2 reset = 1'b0;

    applyStimulus("to200", 0, 1, 32'h0000_0200, 0, 0, 0, 32'h0000_0200, 0, 32'h0, 'x, 0);
    applyStimulus("irq200", 0, 0, 0, 0, 1, 1, 32'h8000_0004, 0, 32'h0, 32'h0000_0200, 1);

    // PC wrap-around from FFFFFFFC
    applyStimulus("toTop", 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'h0, 'x, 0);
    applyStimulus("wrap", 0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 32'h0800_FF03, 32'hFFFF_FFFC, 0);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
